shift_add_mult16: RTL and testbench
===================================

Name: shift_add_mult16

Overview:
- Sequential unsigned multiplier; the direct consumer of the team's 16-bit carry-lookahead adder.
- Each step uses the adder for the partial-product add (operands a/b, cin=0, sum, cout); the adder is instantiated inside this block.
- Sits between an operand source (valid/ready) and a result sink (valid/ready) in the lab datapath.
- Computes one WIDTH x WIDTH -> 2*WIDTH product every WIDTH+1 cycles (1 load + WIDTH steps), plus result-handshake time.

Parameters:
- WIDTH, 16, operand width; only 16 is supported (matches the adder instance). The product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  multiplicand, unsigned.
- in_b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  sink accepts product.
- out_product  output  2*WIDTH  unsigned product.
- busy  output  1  high in RUN state.

Behaviour:
- Reset: one clock, asynchronous and active-high.
  - rst high forces the following immediately, regardless of clk: state=IDLE, in_ready=1, out_valid=0, busy=0, out_product=0, internal regs (mcand, hi, lo, count) = 0.
  - Reset mid-RUN or mid-DONE aborts: the operation is discarded, no out_valid pulse occurs.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - in_ready=1.
  - On the rising edge with in_valid & in_ready:
    - mcand<=in_a, lo<=in_b, hi<=0, count<=0.
    - Go to RUN.
- RUN (exactly WIDTH cycles):
  - in_ready=0, busy=1.
  - Each cycle, adder operands are a=hi, b=(lo[0] ? mcand : 0), cin=0. This gives sum[WIDTH-1:0] and cout.
  - On the edge: {hi,lo} <= {cout, sum, lo} >> 1, i.e. hi<={cout,sum[WIDTH-1:1]} and lo<={sum[0],lo[WIDTH-1:1]}. count<=count+1.
  - When count==WIDTH-1 on that edge: go to DONE and load out_product<={next hi, next lo}.
  - count is 5 bits; it never wraps within an operation.
- DONE:
  - out_valid=1. out_product is held stable while out_valid is high.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - out_product keeps its last value after the handshake; it is not cleared.
  - If out_ready=0 the block stalls in DONE indefinitely; in_ready stays 0 (no input accepted while a result is pending).
- Latency:
  - Operands accepted on edge k; out_valid rises after edge k+WIDTH (16 cycles).
  - Minimum spacing between accepts is WIDTH+2 edges (out_ready tied 1): 1 in IDLE, WIDTH in RUN, 1 in DONE.
- in_valid while not in IDLE: ignored, no side effects. Operands must be held by the source until in_ready is seen.
- in_valid & in_ready sampled only at the edge. Inputs are don't-care when in_valid=0.
- Arithmetic:
  - Fully unsigned; no overflow is possible (the product fits in 2*WIDTH bits).
  - The adder cout must be captured into hi[WIDTH-1]; dropping it is a failure (covered by 0xFFFF*0xFFFF).
- Simultaneous events:
  - rst dominates everything.
  - out_ready in a non-DONE state has no effect.

Test Plan:
- Reset, then 3 x 5: in_valid one cycle with in_a=0x0003, in_b=0x0005 -> out_valid exactly 16 cycles after the accept edge, out_product=0x0000000F, busy high for 16 cycles.
- 0xFFFF x 0xFFFF -> out_product=0xFFFE0001 (exercises cout capture on every step).
- Zero operand: 0x0000 x 0x1234 and 0xABCD x 0x0000 -> 0x00000000. Also 0x8000 x 0x0002 -> 0x00010000.
- Backpressure: 0x1234 x 0x5678 with out_ready=0 for 10 cycles after out_valid -> out_product held at 0x06260060, in_ready=0 throughout; in_valid pulses during the stall are ignored. After out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset mid-operation: assert rst asynchronously (between edges) at RUN count 7 -> outputs go to reset values immediately. A following 0x0002 x 0x0003 -> 0x00000006 with no residue.
- Back-to-back stream: 200 random pairs with out_ready tied 1 and in_valid always high -> each result matches a*b, accepts exactly 18 edges apart, no dropped or duplicated results.

Source files
------------

// File: rtl/shift_add_mult16.sv
// shift_add_mult16: sequential unsigned WIDTH x WIDTH multiplier.
// Each RUN step adds the multiplicand (gated by the current LSB of the
// multiplier) into the high half through a 16-bit carry-lookahead adder.
// The {cout, sum, lo} concatenation then shifts right by one bit.
// The product comes out through a valid/ready handshake.

// 16-bit carry-lookahead adder: 4-bit groups with a second-level lookahead.
module shift_add_mult16_cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_grp
            assign gg[i] = g[4*i+3]
                         | (p[4*i+3] & g[4*i+2])
                         | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                         | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            assign gp[i] = &p[4*i +: 4];
            // Carries inside the group come straight from the group carry-in.
            assign c[4*i]   = gc[i];
            assign c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
            assign c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                            | (p[4*i+1] & p[4*i] & gc[i]);
            assign c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                            | (p[4*i+2] & p[4*i+1] & g[4*i])
                            | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
        end
    endgenerate

    // Second-level lookahead: every group carry-in is formed directly from cin.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    assign sum  = p ^ c;
    assign cout = gc[4];
endmodule

module shift_add_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST = 5'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [4:0]           count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;

    // Partial product: add the multiplicand only when the current multiplier bit is set.
    assign add_b = lo_q[0] ? mcand_q : '0;

    shift_add_mult16_cla16 u_add (
        .a    (hi_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: accept in IDLE, WIDTH steps in RUN, wait for the sink in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)        state_d = RUN;
            RUN:     if (count_q == LAST) state_d = DONE;
            DONE:    if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Outputs decoded from state only, so reset clears them immediately.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == RUN);
        out_valid = (state_q == DONE);
    end

    // Datapath next-state: operand load, shift-add step, product capture.
    always_comb begin
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = in_a;
                    lo_d    = in_b;
                    hi_d    = '0;
                    count_d = '0;
                end
            end
            RUN: begin
                // The adder carry becomes the new MSB of hi; dropping it corrupts large products.
                hi_d    = {add_cout, add_sum[WIDTH-1:1]};
                lo_d    = {add_sum[0], lo_q[WIDTH-1:1]};
                count_d = count_q + 5'd1;
                if (count_q == LAST)
                    product_d = {add_cout, add_sum, lo_q[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    // Datapath registers; the product register keeps its value after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign out_product = product_q;
endmodule

// File: tb/tb_shift_add_mult16.sv
// Bench for shift_add_mult16: directed corner products, backpressure, async
// reset abort and a randomized back-to-back stream, all compared with a*b.
module tb_shift_add_mult16;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    shift_add_mult16 #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference product from plain arithmetic.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        return 32'(a) * 32'(b);
    endfunction

    // One complete operation with the sink always ready; checks latency, busy and result.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
        int cnt;
        int busy_cnt;
        cnt = 0;
        while (!in_ready && cnt < 40) begin tick(); cnt++; end
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom;
        cnt = 0; busy_cnt = 0;
        while (!out_valid && cnt < 40) begin
            if (busy) busy_cnt++;
            tick();
            cnt++;
        end
        chk({tag, "_lat"},  64'(cnt), 64'd16);
        chk({tag, "_busy"}, 64'(busy_cnt), 64'd16);
        chk({tag, "_prod"}, 64'(out_product), 64'(ref_mul(a, b)));
        tick();
        chk({tag, "_idle"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    logic [31:0] expq[$];
    logic [31:0] exp_v;
    logic [31:0] held;
    int          last_acc;
    int          nacc;
    int          nres;
    int          cyc;
    bit          acc_now;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        #12;
        chk("rst_outs", 64'({in_ready, out_valid, busy}), 64'b100);
        chk("rst_prod", 64'(out_product), 64'd0);
        #3 rst = 1'b0;
        tick();

        run_op("m3x5", 16'h0003, 16'h0005);
        chk("m3x5_const", 64'(out_product), 64'h0000000F);
        run_op("mffff", 16'hFFFF, 16'hFFFF);
        chk("mffff_const", 64'(out_product), 64'hFFFE0001);
        run_op("z0", 16'h0000, 16'h1234);
        run_op("z1", 16'hABCD, 16'h0000);
        run_op("m8000", 16'h8000, 16'h0002);
        chk("m8000_const", 64'(out_product), 64'h00010000);

        // Backpressure: hold result for 10 cycles, junk in_valid pulses ignored.
        out_ready = 1'b0;
        in_a = 16'h1234; in_b = 16'h5678; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin tick(); cyc++; end
        chk("bp_lat", 64'(cyc), 64'd16);
        held = out_product;
        chk("bp_prod", 64'(held), 64'h06260060);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; in_a = $urandom; in_b = $urandom;
            tick();
            chk("bp_hold", 64'({out_valid, in_ready, out_product}), {31'd0, 2'b10, 32'h06260060});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release", 64'({in_ready, out_valid, busy}), 64'b100);
        chk("bp_keep", 64'(out_product), 64'h06260060);

        // Async reset while RUN count is 7.
        in_a = 16'h4321; in_b = 16'h8765; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("ar_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_outs", 64'({in_ready, out_valid, busy}), 64'b100);
        chk("ar_prod", 64'(out_product), 64'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        chk("ar_nopulse", 64'(out_valid), 64'd0);
        run_op("ar_after", 16'h0002, 16'h0003);
        chk("ar_after_const", 64'(out_product), 64'h00000006);

        // Back-to-back random stream with in_valid always high.
        nacc = 0; nres = 0; cyc = 0; last_acc = -1;
        in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
        while (nres < 200 && cyc < 200 * 18 + 100) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("st_extra", 64'(out_product), 64'hDEAD);
                end else begin
                    exp_v = expq.pop_front();
                    chk("st_prod", 64'(out_product), 64'(exp_v));
                end
                nres++;
            end
            acc_now = in_ready && in_valid;
            if (acc_now) begin
                expq.push_back(ref_mul(in_a, in_b));
                if (last_acc >= 0) chk("st_space", 64'(cyc - last_acc), 64'd18);
                last_acc = cyc;
                nacc++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                if (nacc < 200) begin in_a = $urandom; in_b = $urandom; end
                else in_valid = 1'b0;
            end
        end
        chk("st_nacc", 64'(nacc), 64'd200);
        chk("st_nres", 64'(nres), 64'd200);
        chk("st_left", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
